// File: rtl/debounce_pkg.sv
// Shared encodings and counter sizing for the multi-channel debouncer.
// No datapath: edge-mode and FSM state constants plus a width helper.
package debounce_pkg;

  localparam int EDGE_PRESS   = 0;
  localparam int EDGE_RELEASE = 1;
  localparam int EDGE_BOTH    = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HELD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchronizer, stability counter, press/hold/repeat FSM.
// Level and pulse update together 2 + DEBOUNCE_THRESHOLD cycles after a clean step; no backpressure.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int INVERT_LOGIC       = 0,
  parameter int DEBOUNCE_THRESHOLD = 5000,
  parameter int EDGE_MODE          = EDGE_PRESS,
  parameter int REPEAT_DELAY       = 0,
  parameter int REPEAT_PERIOD      = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic signal_in,
  output logic level_out,
  output logic pulse_out,
  output logic pulse_nxt
);

  localparam logic RAW_IDLE  = (INVERT_LOGIC != 0);
  localparam int   DB_W      = cnt_width(DEBOUNCE_THRESHOLD - 1);
  localparam int   HOLD_MAX  = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;
  localparam int   RP_MAX    = (HOLD_MAX > REPEAT_PERIOD - 1) ? HOLD_MAX : REPEAT_PERIOD - 1;
  localparam int   RP_W      = cnt_width(RP_MAX);

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_THRESHOLD - 1);
  localparam logic [RP_W-1:0] HOLD_LAST   = RP_W'(HOLD_MAX);
  localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

  localparam logic PULSE_ON_PRESS   = (EDGE_MODE != EDGE_RELEASE);
  localparam logic PULSE_ON_RELEASE = (EDGE_MODE != EDGE_PRESS);
  localparam logic REPEAT_EN        = (REPEAT_DELAY > 0);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            level_q, level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]      state_q, state_d;
  logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;
  logic            pulse_q, pulse_d;
  logic            smp;
  logic            press_acc;
  logic            rel_acc;

  always_comb begin
    sync1_d   = signal_in;
    sync2_d   = sync1_q;
    smp       = sync2_q ^ RAW_IDLE;
    level_d   = level_q;
    db_cnt_d  = '0;
    press_acc = 1'b0;
    rel_acc   = 1'b0;

    // Counter only runs while the sample disagrees; any agreeing cycle restarts it.
    if (smp != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d   = smp;
        press_acc = smp;
        rel_acc   = ~smp;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    state_d  = state_q;
    rp_cnt_d = rp_cnt_q;
    pulse_d  = 1'b0;

    // Release is checked first so it wins over a repeat pulse due in the same cycle.
    case (state_q)
      ST_IDLE: begin
        rp_cnt_d = '0;
        if (press_acc) begin
          state_d = ST_HELD;
          pulse_d = PULSE_ON_PRESS;
        end
      end
      ST_HELD: begin
        if (rel_acc) begin
          state_d  = ST_IDLE;
          rp_cnt_d = '0;
          pulse_d  = PULSE_ON_RELEASE;
        end else if (REPEAT_EN) begin
          if (rp_cnt_q == HOLD_LAST) begin
            state_d  = ST_REPEAT;
            rp_cnt_d = '0;
            pulse_d  = PULSE_ON_PRESS;
          end else begin
            rp_cnt_d = rp_cnt_q + 1'b1;
          end
        end
      end
      ST_REPEAT: begin
        if (rel_acc) begin
          state_d  = ST_IDLE;
          rp_cnt_d = '0;
          pulse_d  = PULSE_ON_RELEASE;
        end else if (rp_cnt_q == PERIOD_LAST) begin
          rp_cnt_d = '0;
          pulse_d  = PULSE_ON_PRESS;
        end else begin
          rp_cnt_d = rp_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        rp_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= RAW_IDLE;
      sync2_q  <= RAW_IDLE;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
      state_q  <= ST_IDLE;
      rp_cnt_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      rp_cnt_q <= rp_cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign level_out = level_q;
  assign pulse_out = pulse_q;
  assign pulse_nxt = pulse_d;

endmodule

// File: rtl/debounce_edge_multi.sv
// N_CH independent debounce channels plus a combined any_pulse flag.
// any_pulse is registered from the channels' next-pulse terms so it aligns with pulse_out; no backpressure.
module debounce_edge_multi
  import debounce_pkg::*;
#(
  parameter int N_CH               = 4,
  parameter int INVERT_LOGIC       = 0,
  parameter int DEBOUNCE_THRESHOLD = 5000,
  parameter int EDGE_MODE          = EDGE_PRESS,
  parameter int REPEAT_DELAY       = 0,
  parameter int REPEAT_PERIOD      = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] signal_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] pulse_out,
  output logic            any_pulse
);

  logic [N_CH-1:0] pulse_nxt;
  logic            any_pulse_q, any_pulse_d;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
        .INVERT_LOGIC      (INVERT_LOGIC),
        .DEBOUNCE_THRESHOLD(DEBOUNCE_THRESHOLD),
        .EDGE_MODE         (EDGE_MODE),
        .REPEAT_DELAY      (REPEAT_DELAY),
        .REPEAT_PERIOD     (REPEAT_PERIOD)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .signal_in(signal_in[i]),
        .level_out(level_out[i]),
        .pulse_out(pulse_out[i]),
        .pulse_nxt(pulse_nxt[i])
      );
    end
  endgenerate

  always_comb any_pulse_d = |pulse_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_pulse_q <= 1'b0;
    else     any_pulse_q <= any_pulse_d;
  end

  assign any_pulse = any_pulse_q;

endmodule

// File: tb/tb_debounce_edge_multi.sv
// Bench: two debouncers (mode 0 active-high, mode 2 active-low) against a window-based model.
// The model accepts a level change when the last TH synchronized samples all disagree with it.
module tb_debounce_edge_multi;

  localparam int TH = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int HD = TH + 2;

  logic       clk;
  logic       rst;
  logic [3:0] sig_a, sig_b;
  logic [3:0] lvl_a, pls_a, lvl_b, pls_b;
  logic       any_a, any_b;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [3:0] hist [2][HD];
  logic [3:0] m_lvl[2];
  logic [3:0] m_pls[2];
  int         m_t  [2][4];

  debounce_edge_multi #(
    .N_CH(4), .INVERT_LOGIC(0), .DEBOUNCE_THRESHOLD(TH),
    .EDGE_MODE(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut_a (
    .clk(clk), .rst(rst), .signal_in(sig_a),
    .level_out(lvl_a), .pulse_out(pls_a), .any_pulse(any_a)
  );

  debounce_edge_multi #(
    .N_CH(4), .INVERT_LOGIC(1), .DEBOUNCE_THRESHOLD(TH),
    .EDGE_MODE(2), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut_b (
    .clk(clk), .rst(rst), .signal_in(sig_b),
    .level_out(lvl_b), .pulse_out(pls_b), .any_pulse(any_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] obs();
    return {lvl_a, pls_a, any_a, lvl_b, pls_b, any_b};
  endfunction

  function automatic logic [17:0] expv();
    return {m_lvl[0], m_pls[0], |m_pls[0], m_lvl[1], m_pls[1], |m_pls[1]};
  endfunction

  // Logical press pattern; the second instance sees it active-low.
  task automatic drive(input logic [3:0] p);
    sig_a = p;
    sig_b = ~p;
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_lvl[u] = 4'h0;
      m_pls[u] = 4'h0;
      for (int c = 0; c < 4; c++) m_t[u][c] = 0;
      for (int j = 0; j < HD; j++) hist[u][j] = (u == 1) ? 4'hF : 4'h0;
    end
  endtask

  task automatic model_step(input int u, input logic [3:0] raw);
    logic inv;
    logic diff;
    int   md;
    inv = (u == 1);
    md  = (u == 0) ? 0 : 2;
    for (int j = HD - 1; j > 0; j--) hist[u][j] = hist[u][j-1];
    hist[u][0] = raw;
    for (int c = 0; c < 4; c++) begin
      diff = 1'b1;
      for (int j = 2; j < HD; j++)
        if ((hist[u][j][c] ^ inv) == m_lvl[u][c]) diff = 1'b0;
      m_pls[u][c] = 1'b0;
      if (diff) begin
        m_lvl[u][c] = ~m_lvl[u][c];
        if (m_lvl[u][c]) begin
          m_t[u][c]   = cyc;
          m_pls[u][c] = (md != 1);
        end else begin
          m_pls[u][c] = (md != 0);
        end
      end else if (m_lvl[u][c] && (cyc - m_t[u][c] >= RD) &&
                   ((cyc - m_t[u][c] - RD) % RP == 0)) begin
        m_pls[u][c] = (md != 1);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step(0, sig_a);
    model_step(1, sig_b);
    #1;
  endtask

  task automatic settle(input int n);
    drive(4'h0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    int seen;
    seen = 0;
    rst = 1'b1;
    drive(4'h0);
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (obs() !== 18'h0) $display("FAIL reset_state got=%h exp=0", obs());
    else n_pass++;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (any_a || any_b) seen++;
      n_total++;
      if (obs() !== expv()) $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      else n_pass++;
    end
    n_total++;
    if (seen !== 0) $display("FAIL reset_no_pulse got=%0d exp=0", seen);
    else n_pass++;
  endtask

  task automatic test_clean_press();
    int rise_at, pulse_at, pulse_cnt, any_cnt;
    rise_at = -1; pulse_at = -1; pulse_cnt = 0; any_cnt = 0;
    drive(4'h0);
    for (int i = 0; i < 10; i++) tick();
    drive(4'h1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_total++;
      if (obs() !== expv()) $display("FAIL clean_press cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      else n_pass++;
      if (lvl_a[0] && rise_at < 0) rise_at = i;
      if (pls_a[0]) begin pulse_cnt++; pulse_at = i; end
      if (any_a) any_cnt++;
    end
    n_total++;
    if (rise_at !== 6) $display("FAIL press_latency got=%0d exp=6", rise_at);
    else n_pass++;
    n_total++;
    if (pulse_cnt !== 1 || pulse_at !== 6) $display("FAIL press_pulse got=%0d@%0d exp=1@6", pulse_cnt, pulse_at);
    else n_pass++;
    n_total++;
    if (any_cnt !== 1) $display("FAIL press_any got=%0d exp=1", any_cnt);
    else n_pass++;
    settle(16);
  endtask

  task automatic test_glitch();
    int touched, pulses, rose;
    touched = 0; pulses = 0; rose = 0;
    drive(4'h2);
    for (int i = 0; i < 15; i++) begin
      if (i == 3) drive(4'h0);
      tick();
      if (lvl_a[1] || pls_a[1] || lvl_b[1] || pls_b[1]) touched++;
      n_total++;
      if (obs() !== expv()) $display("FAIL glitch cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      else n_pass++;
    end
    n_total++;
    if (touched !== 0) $display("FAIL glitch_quiet got=%0d exp=0", touched);
    else n_pass++;
    drive(4'h2);
    for (int i = 0; i < 16; i++) begin
      if (i == 4) drive(4'h0);
      tick();
      if (lvl_a[1]) rose = 1;
      if (pls_a[1]) pulses++;
      n_total++;
      if (obs() !== expv()) $display("FAIL min_pulse cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      else n_pass++;
    end
    n_total++;
    if (rose !== 1 || pulses !== 1) $display("FAIL min_pulse_toggle got=%0d/%0d exp=1/1", rose, pulses);
    else n_pass++;
    settle(12);
  endtask

  task automatic test_repeat();
    int first, n;
    int offs[8];
    int exp_offs[6];
    exp_offs = '{0, 20, 28, 36, 44, 52};
    first = -1; n = 0;
    drive(4'h4);
    for (int i = 1; i <= 80; i++) begin
      if (i == 61) drive(4'h0);
      tick();
      if (pls_a[2]) begin
        if (first < 0) first = i;
        if (n < 8) offs[n] = i - first;
        n++;
      end
      n_total++;
      if (obs() !== expv()) $display("FAIL repeat cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      else n_pass++;
    end
    n_total++;
    if (n !== 6) $display("FAIL repeat_count got=%0d exp=6", n);
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_total++;
      if (n > k && offs[k] !== exp_offs[k]) $display("FAIL repeat_offset k=%0d got=%0d exp=%0d", k, offs[k], exp_offs[k]);
      else if (n <= k) $display("FAIL repeat_offset k=%0d got=none exp=%0d", k, exp_offs[k]);
      else n_pass++;
    end
    n_total++;
    if (lvl_a[2] !== 1'b0) $display("FAIL repeat_release_level got=%b exp=0", lvl_a[2]);
    else n_pass++;
  endtask

  task automatic test_invert_both();
    int pulses;
    pulses = 0;
    drive(4'h8);
    for (int i = 0; i < 30; i++) begin
      if (i == 15) drive(4'h0);
      tick();
      if (pls_b[3]) pulses++;
      n_total++;
      if (obs() !== expv()) $display("FAIL invert_both cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      else n_pass++;
    end
    n_total++;
    if (pulses !== 2 || lvl_b[3] !== 1'b0) $display("FAIL invert_both_pulses got=%0d lvl=%b exp=2 lvl=0", pulses, lvl_b[3]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int all_a, all_b, any_cnt;
    all_a = 0; all_b = 0; any_cnt = 0;
    drive(4'hF);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (pls_a == 4'hF) all_a++;
      if (pls_b == 4'hF) all_b++;
      if (any_a) any_cnt++;
      n_total++;
      if (obs() !== expv()) $display("FAIL simultaneous cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      else n_pass++;
    end
    n_total++;
    if (all_a !== 1 || all_b !== 1 || any_cnt !== 1) $display("FAIL simultaneous_pulse got=%0d/%0d/%0d exp=1/1/1", all_a, all_b, any_cnt);
    else n_pass++;
    settle(12);
  endtask

  task automatic test_reset_mid_repeat();
    int seen;
    seen = 0;
    drive(4'hF);
    for (int i = 0; i < 35; i++) tick();
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (obs() !== 18'h0) $display("FAIL reset_async got=%h exp=0", obs());
    else n_pass++;
    drive(4'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pls_a != 4'h0 || pls_b != 4'h0 || any_a || any_b) seen++;
      n_total++;
      if (obs() !== expv()) $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      else n_pass++;
    end
    n_total++;
    if (seen !== 0) $display("FAIL post_reset_pulse got=%0d exp=0", seen);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] p;
    int left[4];
    p = 4'h0;
    for (int c = 0; c < 4; c++) left[c] = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 4; c++) begin
        left[c]--;
        if (left[c] == 0) begin
          p[c] = ~p[c];
          case ($urandom_range(0, 3))
            0:       left[c] = $urandom_range(1, 3);
            3:       left[c] = $urandom_range(20, 50);
            default: left[c] = $urandom_range(4, 12);
          endcase
        end
      end
      drive(p);
      tick();
      n_total++;
      if (obs() !== expv()) $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      else n_pass++;
    end
    settle(60);
  endtask

  initial begin
    drive(4'h0);
    test_reset();
    test_clean_press();
    test_glitch();
    test_repeat();
    test_invert_both();
    test_back_to_back();
    test_reset_mid_repeat();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
